// File: rtl/cgp_eval_pkg.sv
// cgp_eval_pkg: shared state type, default geometry and helpers for the CGP grid evaluator
package cgp_eval_pkg;
   localparam int N_IN_D  = 4;
   localparam int N_OUT_D = 4;
   localparam int TT_MAX  = 1024;
   localparam int OUT_MAX = 32;
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
   function automatic int n_pat(input int n_in);
      return 1 << n_in;
   endfunction
   function automatic int fit_w(input int n_in, input int n_out);
      return $clog2(n_pat(n_in) * n_out + 1);
   endfunction
   function automatic logic [OUT_MAX-1:0] tgt_slice(input logic [TT_MAX-1:0] tt, input int p, input int n_out);
      return OUT_MAX'(tt >> (p * n_out));
   endfunction
endpackage

// File: rtl/cgp_popcount.sv
// cgp_popcount: combinational count of set bits in a vector
module cgp_popcount #(
   parameter int W  = 4,
   parameter int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  vec,
   output logic [CW-1:0] cnt
);
   // ripple-add every bit of the vector
   always_comb begin
      cnt = '0;
      for (int i = 0; i < W; i++) cnt = cnt + CW'(vec[i]);
   end
endmodule

// File: rtl/cgp_eval_ctrl.sv
// cgp_eval_ctrl: sweeps all input patterns through a CGP grid and scores it against a target truth table; CGP_EVAL_EARLY_EXIT_EN adds a mismatch threshold that ends the sweep early
module cgp_eval_ctrl
   import cgp_eval_pkg::*;
#(
   parameter int N_IN          = N_IN_D,
   parameter int N_OUT         = N_OUT_D,
   parameter int SETTLE_CYCLES = 2,
   parameter int FIT_W         = fit_w(N_IN, N_OUT),
   localparam int N_PAT        = n_pat(N_IN)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [N_OUT*N_PAT-1:0] target_tt,
`ifdef CGP_EVAL_EARLY_EXIT_EN
   input  logic [FIT_W-1:0]       abort_thresh,
   output logic                   early_exit,
`endif
   output logic [N_IN-1:0]        cgp_in,
   input  logic [N_OUT-1:0]       cgp_out,
   output logic                   busy,
   output logic                   done,
   output logic [FIT_W-1:0]       fitness,
   output logic [N_PAT-1:0]       mismatch_vec
);
   localparam logic [7:0] SCNT_INIT = 8'(SETTLE_CYCLES - 1);
   state_t                 state;
   logic [N_OUT*N_PAT-1:0] tt_q;
   logic [N_IN-1:0]        pat;
   logic [7:0]             scnt;
   logic [FIT_W-1:0]       acc, acc_nx;
   logic [N_OUT-1:0]       diff;
   logic [$clog2(N_OUT+1)-1:0] pop;
   logic                   last, stop;
`ifdef CGP_EVAL_EARLY_EXIT_EN
   logic [FIT_W-1:0]       thr_q;
`endif

   cgp_popcount #(.W(N_OUT)) u_pop (.vec(diff), .cnt(pop));

   // compare settled grid outputs with the latched target row and decide whether the sweep ends here
   always_comb begin
      diff   = cgp_out ^ N_OUT'(tgt_slice(TT_MAX'(tt_q), int'(pat), N_OUT));
      acc_nx = acc + FIT_W'(pop);
      last   = &pat;
`ifdef CGP_EVAL_EARLY_EXIT_EN
      stop   = last | (acc_nx > thr_q);
`else
      stop   = last;
`endif
   end

   // sequencer: latch job, hold each pattern for the settle window, sample, publish result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         tt_q         <= '0;
         pat          <= '0;
         scnt         <= '0;
         acc          <= '0;
         cgp_in       <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         fitness      <= '0;
         mismatch_vec <= '0;
`ifdef CGP_EVAL_EARLY_EXIT_EN
         thr_q        <= '0;
         early_exit   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               tt_q         <= target_tt;
               pat          <= '0;
               cgp_in       <= '0;
               acc          <= '0;
               mismatch_vec <= '0;
               scnt         <= SCNT_INIT;
               busy         <= 1'b1;
               state        <= SETTLE;
`ifdef CGP_EVAL_EARLY_EXIT_EN
               thr_q        <= abort_thresh;
               early_exit   <= 1'b0;
`endif
            end
            SETTLE: if (scnt == 8'd0) state <= SAMPLE; else scnt <= scnt - 8'd1;
            SAMPLE: begin
               acc               <= acc_nx;
               mismatch_vec[pat] <= |diff;
               if (stop) begin
                  state   <= DONE;
                  fitness <= acc_nx;
                  done    <= 1'b1;
`ifdef CGP_EVAL_EARLY_EXIT_EN
                  early_exit <= ~last;
`endif
               end else begin
                  pat    <= pat + N_IN'(1);
                  cgp_in <= pat + N_IN'(1);
                  scnt   <= SCNT_INIT;
                  state  <= SETTLE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/cgp_eval_ctrl.md
Name: cgp_eval_ctrl

Overview:
Sequencer that scores one configured CGP LUT grid (4 inputs, 4 outputs).
- On start it sweeps all 2^N_IN input patterns into the grid and waits a settle window on each.
- It samples the grid outputs and compares them against a target truth table, accumulating the mismatch count as fitness.
- Sits between the evolution/host logic and the combinational cgp_module instance.

Parameters:
N_IN, 4, grid input count; N_PAT = 2**N_IN patterns
N_OUT, 4, grid output count
SETTLE_CYCLES, 2, cycles each pattern is held before sampling; legal range 1..255
FIT_W, 7, fitness width = $clog2(N_PAT*N_OUT+1)

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request evaluation; sampled only in IDLE
target_tt  in  N_OUT*N_PAT  target truth table; bits [p*N_OUT +: N_OUT] = expected outputs for pattern p; latched on accepted start
cgp_in  out  N_IN  registered drive to grid inputs (in0 = bit 0)
cgp_out  in  N_OUT  grid outputs (x3_y0 = bit 0), same clock domain, combinational from cgp_in
busy  out  1  high from accepted start through DONE
done  out  1  one-cycle pulse, fitness valid
fitness  out  FIT_W  total mismatched output bits over all patterns
mismatch_vec  out  N_PAT  bit p set if pattern p had at least one mismatched output

Behaviour:
- Reset (async, rst_n=0): state=IDLE; cgp_in=0, busy=0, done=0, fitness=0, mismatch_vec=0; internal acc, pattern and settle counters = 0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> latch target_tt; pattern=0; cgp_in<=0; acc=0; mismatch_vec<=0; settle_cnt=SETTLE_CYCLES-1; busy<=1; go SETTLE.
  - fitness and mismatch_vec hold their previous result until start is accepted.
- SETTLE: each cycle, if settle_cnt==0 go SAMPLE, else decrement. Lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - diff = cgp_out ^ target[pattern]; acc += popcount(diff); mismatch_vec[pattern] <= |diff.
  - If pattern==N_PAT-1 go DONE.
  - Otherwise pattern++, cgp_in<=pattern+1, reload settle_cnt, go SETTLE.
- DONE (1 cycle): fitness<=acc (final, including last sample); done=1; busy stays 1 this cycle; next state IDLE with busy=0.
- Timing:
  - cgp_in is stable for SETTLE_CYCLES+1 cycles per pattern, and sampling occurs on the last of those cycles.
  - Cycles from the start-accept edge to the done pulse = N_PAT*(SETTLE_CYCLES+1)+1 (default 49).
- start while busy: ignored, no queuing. start held high across DONE: re-accepted on the first IDLE cycle.
- No overflow: acc saturates naturally at N_PAT*N_OUT=64, which fits FIT_W.
- Reset mid-operation: immediate return to the reset values above; a partial result is never presented.
- target_tt changes while busy have no effect.

Optional Feature:
Macro CGP_EVAL_EARLY_EXIT_EN.
- Defined:
  - Adds input `abort_thresh` (FIT_W).
  - In SAMPLE, if the new acc > abort_thresh, go DONE immediately. fitness=acc at that point; mismatch_vec bits for unvisited patterns stay 0.
  - Adds output `early_exit` (1), asserted with done when this path was taken and cleared on the next accepted start; reset value 0.
  - abort_thresh is latched on start.
- Undefined: no extra ports; the full sweep is always run.

Decomposition:
Package cgp_eval_pkg holds:
- state enum {IDLE, SETTLE, SAMPLE, DONE};
- default N_IN/N_OUT constants;
- N_PAT and FIT_W derivations;
- a target-slice helper function.

One sub-module: cgp_popcount (parameterised width N_OUT, purely combinational), instantiated on the diff vector.

Test Plan:
- Target equals the grid's actual truth table; start pulse -> done after exactly 49 cycles, fitness=0, mismatch_vec=16'h0000.
- Target = bitwise inverse of the actual truth table -> fitness=64, mismatch_vec=16'hFFFF.
- Actual table with bit 2 of pattern 5 flipped -> fitness=1, mismatch_vec=16'h0020. Check cgp_in steps 0..15, each held 3 cycles.
- start re-pulsed at cycle 10 of a run -> ignored; single done at cycle 49; result unaffected.
- rst_n asserted at cycle 20 -> all outputs 0 the same cycle, no done. A new start afterwards runs a clean 49-cycle evaluation.
- With CGP_EVAL_EARLY_EXIT_EN, inverted target, abort_thresh=10 -> done after pattern 2's SAMPLE (acc=12), fitness=12, early_exit=1, mismatch_vec=16'h0007.
